streaming_fifo_hwm: RTL and testbench
=====================================

Name: streaming_fifo_hwm

Overview:
- Parametrised successor of the single-channel Q_srl-based StreamingFIFO used between FINN dataflow layers.
- Generalises width and depth (any DEPTH ≥ 2, not only powers of two) and adds a clearable high-water mark plus registered almost-full and almost-empty flags for throttling and FIFO-sizing runs.
- Sits on AXI-Stream edges between HLS layer IPs. Storage is a circular buffer in inferred simple-dual-port RAM.

Parameters:
- WIDTH, 16, data bits per word.
- DEPTH, 1152, capacity in words; ≥ 2; need not be a power of two.
- AF_THRESH, DEPTH-4, almost_full asserts when count ≥ AF_THRESH.
- AE_THRESH, 4, almost_empty asserts when count ≤ AE_THRESH.
- CNT_W, clog2(DEPTH+1), width of count and maxcount (derived; do not override).

Ports:
- ap_clk  in  1  clock; all logic rising-edge.
- ap_rst_n  in  1  reset, synchronous, active-low.
- in0_V_TDATA  in  WIDTH  write data.
- in0_V_TVALID  in  1  write valid.
- in0_V_TREADY  out  1  write ready.
- out_V_TDATA  out  WIDTH  read data.
- out_V_TVALID  out  1  read valid.
- out_V_TREADY  in  1  read ready.
- count  out  CNT_W  current occupancy.
- maxcount  out  CNT_W  high-water mark of count.
- maxcount_clr  in  1  synchronous clear of the high-water mark.
- almost_full  out  1  count ≥ AF_THRESH, registered.
- almost_empty  out  1  count ≤ AE_THRESH, registered.

Behaviour:
- Reset (ap_rst_n low at a clock edge):
  - count=0, maxcount=0, wr_ptr=rd_ptr=0.
  - in0_V_TREADY=0, out_V_TVALID=0, almost_full=0, almost_empty=1.
  - Mid-operation reset discards all contents. No handshake completes in a reset cycle.
- Push: occurs when in0_V_TVALID & in0_V_TREADY. Pop: occurs when out_V_TVALID & out_V_TREADY.
- in0_V_TREADY is registered: 1 iff count < DEPTH; goes to 1 on the first cycle after reset release.
  - No combinational ready path: when full, a pop in the same cycle does not permit a push. Ready reasserts the next cycle.
- Pointers: wr_ptr/rd_ptr advance on push/pop and wrap from DEPTH-1 to 0.
- count_next = count + push − pop. Simultaneous push and pop leaves count unchanged.
- Latency, base build: a word pushed at edge N appears on out_V_TDATA with out_V_TVALID=1 after edge N+1 when the FIFO was empty.
  - out_V_TVALID = (count != 0), taking read latency into account.
  - out_V_TDATA is held stable while TVALID=1 and TREADY=0.
- Ordering: strict FIFO; no data loss or duplication.
- maxcount:
  - Each cycle maxcount ← max(maxcount, count_next).
  - When maxcount_clr=1, maxcount ← count_next, taking priority over the max update.
- Flags: almost_full and almost_empty are registered from count_next, so they change in the same cycle as count.
- Thresholds outside 0..DEPTH are a compile-time error (elaboration assertion).

Optional Feature:
- Macro: STREAMING_FIFO_HWM_OREG_EN.
- Defined:
  - Adds an output register after the RAM read port for timing.
  - Write-to-out_V_TVALID latency is 2 cycles when empty.
  - count includes the word held in the output register; total capacity stays DEPTH.
  - The prefetch keeps full throughput (1 word/cycle sustained with TREADY held high).
- Undefined: base build, 1-cycle latency, no extra register.

Decomposition:
- Package streaming_fifo_pkg: clog2-based cnt_width function and a ptr_wrap helper (increment modulo DEPTH).
- Sub-module sdp_ram: WIDTH×DEPTH simple dual-port RAM, synchronous write, synchronous read. It contains no control logic.

Test Plan:
- DEPTH=4, WIDTH=16: push 0x0001..0x0004 with out_V_TREADY=0 → count=4, in0_V_TREADY=0 next cycle. A 5th TVALID is not accepted. maxcount=4.
- Full FIFO, drive push and pop in the same cycle → pop only, count=3; TREADY=1 one cycle later.
- DEPTH=5, stream 1000 incrementing words with random valid/ready → output is exactly 0..999 in order. Pointers wrap at 4 with no gap.
- Push one word into an empty FIFO → out_V_TVALID rises after 1 edge (2 with STREAMING_FIFO_HWM_OREG_EN); TDATA matches and is held while TREADY=0.
- Fill to 6 of DEPTH=8 with AF=6, AE=2 → almost_full=1. Pop to 2 → almost_empty=1. Pulse maxcount_clr at count=2 → maxcount=2.
- Deassert ap_rst_n with count=3 → next cycle count=0, out_V_TVALID=0, maxcount=0. After release, a new push is read back correctly.

Source files
------------

// File: rtl/streaming_fifo_pkg.sv
// Shared helpers for streaming_fifo_hwm: the counter width rule and the
// modulo-DEPTH pointer increment used for non-power-of-two depths.
package streaming_fifo_pkg;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_wrap(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// WIDTH x DEPTH simple dual-port RAM: synchronous write, registered read.
// The read register holds its value whenever re is low.
module sdp_ram #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 1152,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/streaming_fifo_hwm.sv
// AXI-Stream FIFO with high-water mark and registered almost flags.
// Define STREAMING_FIFO_HWM_OREG_EN to add an output register after the RAM.
//
// Handshake: a transfer happens on a rising edge where TVALID and TREADY are
// both high; TREADY is registered, TDATA is stable while TVALID && !TREADY.
module streaming_fifo_hwm
  import streaming_fifo_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 1152,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4,
  parameter int CNT_W     = cnt_width(DEPTH)
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [WIDTH-1:0] in0_V_TDATA,
  input  logic             in0_V_TVALID,
  output logic             in0_V_TREADY,
  output logic [WIDTH-1:0] out_V_TDATA,
  output logic             out_V_TVALID,
  input  logic             out_V_TREADY,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] maxcount,
  input  logic             maxcount_clr,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  if (DEPTH < 2) begin : g_bad_depth
    $error("streaming_fifo_hwm: DEPTH must be at least 2");
  end
  if (AF_THRESH < 0 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("streaming_fifo_hwm: AF_THRESH must lie in 0..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH) begin : g_bad_ae
    $error("streaming_fifo_hwm: AE_THRESH must lie in 0..DEPTH");
  end

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_next, held, ram_cnt;
  logic [WIDTH-1:0] ram_rdata;
  logic             push, pop, rd_en, rvalid;

  assign push = in0_V_TVALID & in0_V_TREADY;
  assign pop  = out_V_TVALID & out_V_TREADY;
  // Words still in the RAM array, i.e. not yet moved into a read-side register.
  assign ram_cnt = count - held;

  sdp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(PTR_W)
  ) u_ram (
    .clk  (ap_clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(in0_V_TDATA),
    .re   (rd_en),
    .raddr(rd_ptr),
    .rdata(ram_rdata)
  );

`ifdef STREAMING_FIFO_HWM_OREG_EN
  logic             ovalid, adv;
  logic [WIDTH-1:0] odata;

  // The RAM read register refills while the output register drains, so a
  // continuously ready sink still sees one word per cycle.
  assign adv          = rvalid & (~ovalid | pop);
  assign rd_en        = (ram_cnt != '0) & (~rvalid | adv);
  assign held         = CNT_W'(rvalid) + CNT_W'(ovalid);
  assign out_V_TVALID = ovalid;
  assign out_V_TDATA  = odata;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      rvalid <= 1'b0;
      ovalid <= 1'b0;
    end else begin
      if (rd_en)    rvalid <= 1'b1;
      else if (adv) rvalid <= 1'b0;
      if (adv)      ovalid <= 1'b1;
      else if (pop) ovalid <= 1'b0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (adv) odata <= ram_rdata;
  end
`else
  assign rd_en        = (ram_cnt != '0) & (~rvalid | pop);
  assign held         = CNT_W'(rvalid);
  assign out_V_TVALID = rvalid;
  assign out_V_TDATA  = ram_rdata;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n)     rvalid <= 1'b0;
    else if (rd_en)    rvalid <= 1'b1;
    else if (pop)      rvalid <= 1'b0;
  end
`endif

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CNT_W'(1);
    else if (pop && !push) count_next = count - CNT_W'(1);
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      count        <= '0;
      maxcount     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      in0_V_TREADY <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      count <= count_next;
      if (push)  wr_ptr <= PTR_W'(ptr_wrap(32'(wr_ptr), DEPTH));
      // The read pointer tracks RAM reads; the prefetched word still counts.
      if (rd_en) rd_ptr <= PTR_W'(ptr_wrap(32'(rd_ptr), DEPTH));
      in0_V_TREADY <= (count_next < DEPTH_C);
      if (maxcount_clr)             maxcount <= count_next;
      else if (count_next > maxcount) maxcount <= count_next;
      almost_full  <= (count_next >= AF_C);
      almost_empty <= (count_next <= AE_C);
    end
  end

endmodule

// File: tb/tb_streaming_fifo_hwm.sv
// Self-checking bench for streaming_fifo_hwm (DEPTH=5, AF=4, AE=2) with a
// queue-based occupancy model and a data scoreboard fed from accepted pushes.
module tb_streaming_fifo_hwm;

  localparam int WIDTH = 16;
  localparam int DEPTH = 5;
  localparam int AF    = 4;
  localparam int AE    = 2;
  localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef STREAMING_FIFO_HWM_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] count, maxcount;
  logic             clr = 1'b0;
  logic             af, ae;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;

  logic [WIDTH-1:0] exp_q[$];
  int  m_cnt = 0, m_max = 0;
  bit  m_rdy = 0, m_af = 0, m_ae = 1, armed = 0;
  bit  hs_push, hs_pop;
  logic [WIDTH-1:0] exp_word;

  streaming_fifo_hwm #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .ap_clk      (clk),
    .ap_rst_n    (rst_n),
    .in0_V_TDATA (in_data),
    .in0_V_TVALID(in_valid),
    .in0_V_TREADY(in_ready),
    .out_V_TDATA (out_data),
    .out_V_TVALID(out_valid),
    .out_V_TREADY(out_ready),
    .count       (count),
    .maxcount    (maxcount),
    .maxcount_clr(clr),
    .almost_full (af),
    .almost_empty(ae)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold a word on the input until accepted.
  task automatic push_word(input logic [WIDTH-1:0] d);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    do begin
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: word %h not accepted after %0d cycles", d, n);
    end
  endtask

  task automatic pop_n(input int k);
    int got, n;
    got = 0;
    n = 0;
    out_ready = 1'b1;
    while (got < k && n < 100) begin
      if (out_valid) got++;
      tick();
      n++;
    end
    out_ready = 1'b0;
    chk("pop_n_completed", got, k);
  endtask

  // Monitor: check DUT state against the model, then advance the model by the
  // handshakes that the coming rising edge will complete.
  always @(negedge clk) begin
    hs_push = in_valid && in_ready && rst_n;
    hs_pop  = out_valid && out_ready && rst_n;
    if (armed) begin
      chk("count", int'(count), m_cnt);
      chk("maxcount", int'(maxcount), m_max);
      chk("in_ready", int'(in_ready), int'(m_rdy));
      chk("almost_full", int'(af), int'(m_af));
      chk("almost_empty", int'(ae), int'(m_ae));
      if (m_cnt == 0) chk("valid_when_empty", int'(out_valid), 0);
      if (hs_pop) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got data %h with nothing outstanding", out_data);
        end else begin
          exp_word = exp_q.pop_front();
          chk("out_data", int'(out_data), int'(exp_word));
          rx_cnt++;
        end
      end
    end
    if (!rst_n) begin
      armed = 1;
      m_cnt = 0; m_max = 0; m_rdy = 0; m_af = 0; m_ae = 1;
      exp_q.delete();
    end else if (armed) begin
      if (hs_push) exp_q.push_back(in_data);
      m_cnt = m_cnt + int'(hs_push) - int'(hs_pop);
      m_max = clr ? m_cnt : ((m_cnt > m_max) ? m_cnt : m_max);
      m_rdy = (m_cnt < DEPTH);
      m_af  = (m_cnt >= AF);
      m_ae  = (m_cnt <= AE);
    end
  end

  initial begin
    int sent, cyc, rx_start;
    bit acc;

    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_count", int'(count), 0);
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_ae", int'(ae), 1);
    rst_n = 1'b1;
    tick();
    chk("ready_after_release", int'(in_ready), 1);

    // Latency into empty FIFO and data hold under backpressure
    push_word(16'hBEEF);
    chk("lat_valid_edge0", int'(out_valid), 0);
    for (int i = 1; i < LAT; i++) begin
      tick();
      chk("lat_valid_early", int'(out_valid), 0);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("lat_valid_hold", int'(out_valid), 1);
      chk("lat_data_hold", int'(out_data), 16'hBEEF);
      tick();
    end
    pop_n(1);
    tick(); tick();

    // Fill to full, extra word refused, pop while full admits no push
    for (int i = 1; i <= DEPTH; i++) push_word(WIDTH'(i));
    chk("full_count", int'(count), DEPTH);
    chk("full_ready", int'(in_ready), 0);
    chk("full_maxcount", int'(maxcount), DEPTH);
    in_valid = 1'b1;
    in_data  = 16'h0006;
    tick(); tick(); tick();
    chk("full_refuses", int'(count), DEPTH);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pop_while_full_count", int'(count), DEPTH - 1);
    chk("ready_after_pop", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("refill_count", int'(count), DEPTH);
    pop_n(DEPTH);
    tick(); tick();

    // Flags and high-water clear
    for (int i = 0; i < AF; i++) push_word(WIDTH'(16'h0010 + i));
    chk("af_set", int'(af), 1);
    pop_n(AF - AE);
    tick(); tick();
    chk("ae_count", int'(count), AE);
    chk("ae_set", int'(ae), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("maxcount_after_clr", int'(maxcount), AE);
    pop_n(AE);
    tick(); tick();

    // Mid-operation reset discards contents
    for (int i = 0; i < 3; i++) push_word(WIDTH'(16'h0A00 + i));
    rst_n = 1'b0;
    tick();
    chk("midrst_count", int'(count), 0);
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_maxcount", int'(maxcount), 0);
    rst_n = 1'b1;
    tick();
    rx_start = rx_cnt;
    push_word(16'h1234);
    pop_n(1);
    chk("post_reset_readback", rx_cnt - rx_start, 1);
    tick(); tick();

    // Random valid/ready stream of incrementing words
    sent = 0;
    cyc = 0;
    rx_start = rx_cnt;
    while ((sent < 1000 || rx_cnt < rx_start + 1000) && cyc < 20000) begin
      if (!in_valid && sent < 1000) in_valid = ($urandom_range(0, 3) != 0);
      in_data   = WIDTH'(sent);
      out_ready = ($urandom_range(0, 3) != 0);
      acc = in_valid && in_ready;
      tick();
      cyc++;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("stream_sent", sent, 1000);
    chk("stream_received", rx_cnt - rx_start, 1000);
    tick(); tick();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
